// File: rtl/btn_conditioner.sv
// Purpose: synchronize and debounce the two raw push-buttons for the paddle stage.
// Latency: DB_CYCLES+2 rising edges from a held raw change to every registered output.
// Backpressure: none; outputs are held levels plus a one-clock press pulse, sampled at will.
//
// Ports:
//   i_clk     base clock, all state on its rising edge
//   i_rst_n   asynchronous active-low reset
//   i_btn_r   raw right button (active-high, asynchronous)
//   i_btn_l   raw left button (active-high, asynchronous)
//   o_btn_lr  debounced direction, bit 0 = right, bit 1 = left
//   o_active  high while either debounced button is pressed
//   o_press   one-clock pulse on any debounced 0->1 transition
//
// Optional build macro: BTN_LOCKOUT_EN -- when defined, both buttons held
// reports no direction (o_btn_lr = 2'b00); o_active/o_press are unaffected.

module btn_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_r,
    input  logic       i_btn_l,
    output logic [1:0] o_btn_lr,
    output logic       o_active,
    output logic       o_press
);

    // Terminal count: the change is accepted on the edge where the counter
    // has already seen DB_CYCLES-1 differing cycles and sees one more.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Index 0 = right, index 1 = left throughout.
    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [1:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       btn_lr_q, btn_lr_d;
    logic             active_q, active_d;
    logic             press_q, press_d;

    always_comb begin
        s1_d     = {i_btn_l, i_btn_r};
        s2_d     = s1_q;
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            // Any cycle that agrees with the accepted state restarts the
            // count, so a glitch shorter than DB_CYCLES leaves no trace.
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        // Outputs are registered from the next stable value so they change
        // on the same edge as the stable bits themselves.
        active_d = |stable_d;
        press_d  = |(stable_d & ~stable_q);
`ifdef BTN_LOCKOUT_EN
        btn_lr_d = (&stable_d) ? 2'b00 : stable_d;
`else
        btn_lr_d = stable_d;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
            btn_lr_q <= '0;
            active_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            btn_lr_q <= btn_lr_d;
            active_q <= active_d;
            press_q  <= press_d;
        end
    end

    assign o_btn_lr = btn_lr_q;
    assign o_active = active_q;
    assign o_press  = press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    logic       clk;
    logic       rst_n;
    logic       btn_r;
    logic       btn_l;
    logic [1:0] btn_lr;
    logic       active;
    logic       press;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    btn_conditioner #(
        .DB_CYCLES(4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_btn_r  (btn_r),
        .i_btn_l  (btn_l),
        .o_btn_lr (btn_lr),
        .o_active (active),
        .o_press  (press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every press pulse on the falling edge, away from output updates.
    always @(negedge clk) begin
        if (press) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, stopping 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [1:0] both_exp;
`ifdef BTN_LOCKOUT_EN
        both_exp = 2'b00;
`else
        both_exp = 2'b11;
`endif
        rst_n = 1'b0;
        btn_r = 1'b1;
        btn_l = 1'b1;

        // Reset held with both buttons high
        step(10);
        check("rst_lr", 32'(btn_lr), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        check("rst_press", 32'(press), 32'h0);
        check("rst_pulses", 32'(pulses), 32'd0);

        // Release reset at edge 0, right button kept alone
        rst_n = 1'b1;
        btn_l = 1'b0;
        step(5);
        check("press_e5_lr", 32'(btn_lr), 32'h0);
        check("press_e5_press", 32'(press), 32'h0);
        step(1);
        check("press_e6_lr", 32'(btn_lr), 32'h1);
        check("press_e6_active", 32'(active), 32'h1);
        check("press_e6_press", 32'(press), 32'h1);
        step(1);
        check("press_e7_press", 32'(press), 32'h0);
        check("press_e7_lr", 32'(btn_lr), 32'h1);

        // Release right button: no pulse
        btn_r = 1'b0;
        step(5);
        check("rel_e5_lr", 32'(btn_lr), 32'h1);
        check("rel_e5_active", 32'(active), 32'h1);
        step(1);
        check("rel_e6_lr", 32'(btn_lr), 32'h0);
        check("rel_e6_active", 32'(active), 32'h0);
        check("rel_e6_press", 32'(press), 32'h0);
        step(2);
        check("rel_pulses", 32'(pulses), 32'd1);

        // Glitch: left high for exactly 3 clocks
        btn_l = 1'b1;
        step(3);
        btn_l = 1'b0;
        step(2);
        check("glitch_cnt_peak", 32'(dut.cnt_q[1]), 32'd3);
        step(1);
        check("glitch_cnt_clear", 32'(dut.cnt_q[1]), 32'd0);
        step(4);
        check("glitch_lr", 32'(btn_lr), 32'h0);
        check("glitch_pulses", 32'(pulses), 32'd1);

        // Bounce: toggle every 2 clocks for 20 clocks, then hold
        for (int k = 0; k < 5; k++) begin
            btn_l = 1'b1;
            step(2);
            btn_l = 1'b0;
            step(2);
        end
        check("bounce_pre_pulses", 32'(pulses), 32'd1);
        check("bounce_pre_lr", 32'(btn_lr), 32'h0);
        btn_l = 1'b1;
        step(5);
        check("bounce_e5_press", 32'(press), 32'h0);
        check("bounce_e5_lr", 32'(btn_lr), 32'h0);
        step(1);
        check("bounce_e6_press", 32'(press), 32'h1);
        check("bounce_e6_lr", 32'(btn_lr), 32'h2);
        check("bounce_e6_active", 32'(active), 32'h1);
        step(2);
        check("bounce_pulses", 32'(pulses), 32'd2);

        // Both pressed together
        btn_l = 1'b0;
        step(8);
        check("both_pre_active", 32'(active), 32'h0);
        btn_r = 1'b1;
        btn_l = 1'b1;
        step(5);
        check("both_e5_press", 32'(press), 32'h0);
        step(1);
        check("both_e6_press", 32'(press), 32'h1);
        check("both_e6_active", 32'(active), 32'h1);
        check("both_e6_lr", 32'(btn_lr), 32'(both_exp));
        step(1);
        check("both_e7_press", 32'(press), 32'h0);
        step(1);
        check("both_pulses", 32'(pulses), 32'd3);

        // Mid-count reset, then full latency again
        btn_r = 1'b0;
        btn_l = 1'b0;
        step(8);
        check("mid_pre_active", 32'(active), 32'h0);
        check("mid_pre_pulses", 32'(pulses), 32'd3);
        btn_r = 1'b1;
        step(4);
        check("mid_cnt2", 32'(dut.cnt_q[0]), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(dut.cnt_q[0]), 32'd0);
        check("mid_rst_lr", 32'(btn_lr), 32'h0);
        step(3);
        rst_n = 1'b1;
        step(5);
        check("mid_e5_lr", 32'(btn_lr), 32'h0);
        step(1);
        check("mid_e6_lr", 32'(btn_lr), 32'h1);
        check("mid_e6_press", 32'(press), 32'h1);
        step(2);
        check("mid_pulses", 32'(pulses), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
